// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: strobes the selected unit for a fixed number of
// cycles, captures its result into z_out, then pulses done.
module alu_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] Chigh,
  input  logic [31:0] Clow,
  output logic [12:0] alu_sel,
  output logic [63:0] z_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShra = 5'b00110;
  localparam logic [4:0] OpShl  = 5'b00111;
  localparam logic [4:0] OpRor  = 5'b01000;
  localparam logic [4:0] OpRol  = 5'b01001;
  localparam logic [4:0] OpAnd  = 5'b01010;
  localparam logic [4:0] OpOr   = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  typedef enum logic [1:0] {StIdle, StExec, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [63:0] z_q, z_d;
  logic        err_q, err_d;

  // An all-zero decode doubles as the "undefined opcode" indication.
  function automatic logic [12:0] decode_op(input logic [4:0] op);
    logic [12:0] sel;
    sel = '0;
    case (op)
      OpAdd:   sel = 13'h0001;
      OpSub:   sel = 13'h0002;
      OpMul:   sel = 13'h0004;
      OpDiv:   sel = 13'h0008;
      OpAnd:   sel = 13'h0010;
      OpOr:    sel = 13'h0020;
      OpShr:   sel = 13'h0040;
      OpShra:  sel = 13'h0080;
      OpShl:   sel = 13'h0100;
      OpRor:   sel = 13'h0200;
      OpRol:   sel = 13'h0400;
      OpNeg:   sel = 13'h0800;
      OpNot:   sel = 13'h1000;
      default: sel = '0;
    endcase
    return sel;
  endfunction

  logic        req_legal;
  logic [4:0]  cnt_load;
  logic        wide_op;

  assign req_legal = |decode_op(opcode);
  assign cnt_load  = (opcode == OpMul) ? 5'd15 : (opcode == OpDiv) ? 5'd31 : 5'd0;
  assign wide_op   = (op_q == OpMul) || (op_q == OpDiv);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    z_d     = z_q;
    err_d   = 1'b0;
    alu_sel = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (req_legal) begin
            op_d    = opcode;
            cnt_d   = cnt_load;
            state_d = StExec;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StExec: begin
        alu_sel = decode_op(op_q);
        busy    = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StCapture: begin
        alu_sel = decode_op(op_q);
        busy    = 1'b1;
        z_d     = wide_op ? {Chigh, Clow} : {32'h0, Clow};
        state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign z_out = z_q;
  assign err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed checks of alu_sequencer against an opcode-table model.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] Chigh;
  logic [31:0] Clow;
  logic [12:0] alu_sel;
  logic [63:0] z_out;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] z_model = 64'h0;

  // Legal opcodes listed in alu_sel bit order.
  int unsigned op_table [13] = '{3, 4, 15, 16, 10, 11, 5, 6, 7, 8, 9, 17, 18};

  alu_sequencer dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .opcode  (opcode),
    .Chigh   (Chigh),
    .Clow    (Clow),
    .alu_sel (alu_sel),
    .z_out   (z_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  function automatic int sel_index(input logic [4:0] op);
    for (int i = 0; i < 13; i++) begin
      if (op_table[i] == 32'(op)) return i;
    end
    return -1;
  endfunction

  function automatic int exec_len(input logic [4:0] op);
    if (op == 5'd15) return 16;
    if (op == 5'd16) return 32;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, ".sel"},  64'(alu_sel), 64'h0);
    chk({tag, ".busy"}, 64'(busy),    64'h0);
    chk({tag, ".done"}, 64'(done),    64'h0);
    chk({tag, ".z"},    z_out,        z_model);
  endtask

  // Issues one legal op from IDLE and checks every cycle until back in IDLE.
  task automatic run_op(input logic [4:0] op, input logic [31:0] hi, input logic [31:0] lo,
                        input bit hold_start);
    int          n;
    logic [12:0] exp_sel;
    n       = exec_len(op);
    exp_sel = 13'(1) << sel_index(op);
    opcode  = op;
    Chigh   = $urandom;
    Clow    = $urandom;
    start   = 1'b1;
    step();
    for (int c = 0; c <= n; c++) begin
      chk("run.sel",  64'(alu_sel), 64'(exp_sel));
      chk("run.busy", 64'(busy),    64'h1);
      chk("run.done", 64'(done),    64'h0);
      chk("run.err",  64'(err),     64'h0);
      chk("run.z",    z_out,        z_model);
      opcode = 5'($urandom);
      start  = hold_start ? 1'b1 : 1'($urandom);
      if (c == n) begin
        Chigh = hi;
        Clow  = lo;
      end else begin
        Chigh = $urandom;
        Clow  = $urandom;
      end
      step();
    end
    z_model = (op == 5'd15 || op == 5'd16) ? {hi, lo} : {32'h0, lo};
    chk("done.sel",  64'(alu_sel), 64'h0);
    chk("done.busy", 64'(busy),    64'h1);
    chk("done.done", 64'(done),    64'h1);
    chk("done.err",  64'(err),     64'h0);
    chk("done.z",    z_out,        z_model);
    step();
    idle_checks("post");
    chk("post.err", 64'(err), 64'h0);
    start = 1'b0;
  endtask

  task automatic run_illegal(input logic [4:0] op);
    opcode = op;
    start  = 1'b1;
    step();
    chk("ill.err", 64'(err), 64'h1);
    idle_checks("ill");
    start = 1'b0;
    step();
    chk("ill.err_gone", 64'(err), 64'h0);
    idle_checks("ill2");
  endtask

  function automatic logic [4:0] rand_illegal();
    logic [4:0] v;
    v = 5'($urandom);
    while (sel_index(v) >= 0) v = 5'($urandom);
    return v;
  endfunction

  initial begin
    clear  = 1'b1;
    start  = 1'b0;
    opcode = 5'd0;
    Chigh  = 32'h0;
    Clow   = 32'h0;
    step();
    step();
    idle_checks("reset");
    chk("reset.err", 64'(err), 64'h0);
    clear = 1'b0;
    step();

    // Directed: ADD, MUL, wide-ignore on single-cycle op, illegal then NOT
    run_op(5'd3, 32'hDEAD_BEEF, 32'h0000_0005, 1'b0);
    chk("add.z", z_out, 64'h0000_0000_0000_0005);
    run_op(5'd15, 32'h0000_0001, 32'h8000_0000, 1'b0);
    chk("mul.z", z_out, 64'h0000_0001_8000_0000);
    run_op(5'd4, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    chk("sub.zhi", 64'(z_out[63:32]), 64'h0);
    run_illegal(5'd0);
    run_op(5'd18, 32'h0, 32'hCAFE_F00D, 1'b0);

    // start held high through AND then OR
    run_op(5'd10, 32'h1, 32'h0000_00AA, 1'b1);
    run_op(5'd11, 32'h2, 32'h0000_0055, 1'b1);

    // clear during DIV EXEC cycle 10
    opcode = 5'd16;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      chk("div.sel", 64'(alu_sel), 64'h0008);
      step();
    end
    clear = 1'b1;
    step();
    clear   = 1'b0;
    z_model = 64'h0;
    idle_checks("divclr");
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) chk("divclr.quiet", {62'h0, done, busy}, 64'h0);
      step();
    end
    chk("divclr.end_done", 64'(done), 64'h0);

    // clear beats start, legal and illegal
    opcode = 5'd7;
    start  = 1'b1;
    clear  = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    idle_checks("clrstart");
    step();
    idle_checks("clrstart2");
    chk("clrstart.err", 64'(err), 64'h0);
    opcode = rand_illegal();
    start  = 1'b1;
    clear  = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    chk("clrill.err", 64'(err), 64'h0);
    step();
    chk("clrill.err2", 64'(err), 64'h0);

    // Random mix of legal and illegal requests
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        run_illegal(rand_illegal());
      end else begin
        run_op(5'(op_table[$urandom_range(0, 12)]), $urandom, $urandom, 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
